// File: rtl/spi_pkg.sv
// spi_pkg: frame widths, peripheral register map and FSM
// state type shared by the SPI Mode 0 controller files.
package spi_pkg;

  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;

  localparam logic [ADDR_W-1:0] REG_EN_OUT_7_0  = 7'd0;
  localparam logic [ADDR_W-1:0] REG_EN_OUT_15_8 = 7'd1;
  localparam logic [ADDR_W-1:0] REG_EN_PWM_7_0  = 7'd2;
  localparam logic [ADDR_W-1:0] REG_EN_PWM_15_8 = 7'd3;
  localparam logic [ADDR_W-1:0] REG_PWM_DUTY    = 7'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } spi_state_e;

  function automatic logic [FRAME_W-1:0] pack_frame(
    input logic              rw,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    return {rw, addr, data};
  endfunction

endpackage

// File: rtl/spi_controller_clk_gen.sv
// spi_clk_gen: half-period divider, SCLK toggle flop and
// half-period (edge) counter with rise/fall strobes.
module spi_clk_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic       tog_en,
  input  logic [7:0] div_top,
  output logic       half_done,
  output logic       rise,
  output logic       fall,
  output logic       sclk,
  output logic [4:0] edge_cnt
);

  logic [7:0] hcnt_q, hcnt_d;
  logic [4:0] edge_q, edge_d;
  logic       sclk_q, sclk_d;

  assign half_done = en && (hcnt_q == div_top);
  assign rise      = tog_en && half_done && !sclk_q;
  assign fall      = tog_en && half_done && sclk_q;
  assign sclk      = sclk_q;
  assign edge_cnt  = edge_q;

  // Divider wraps each half-period; edge count restarts per state.
  always_comb begin
    hcnt_d = hcnt_q + 8'd1;
    if (!en || half_done) hcnt_d = '0;
    edge_d = edge_q;
    if (clr) edge_d = '0;
    else if (half_done) edge_d = edge_q + 5'd1;
    sclk_d = sclk_q ^ (tog_en && half_done);
  end

  // Divider, edge counter and SCLK registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q <= '0;
      edge_q <= '0;
      sclk_q <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      edge_q <= edge_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_controller.sv
// spi_controller: SPI Mode 0 frame writer (16-bit, MSB first).
// Optional CIPO readback under macro SPI_CTRL_READBACK_EN.
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_HALVES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              SCLK,
  output logic              COPI,
  output logic              nCS,
  output logic              busy,
  output logic              done
`ifdef SPI_CTRL_READBACK_EN
  ,
  input  logic              CIPO,
  output logic [DATA_W-1:0] rsp_data
`endif
);

  spi_state_e         state_q, state_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic               ncs_q, ncs_d;
  logic               done_q, done_d;
  logic               half_done, rise, fall, sclk;
  logic               accept, last_gap;
  logic [4:0]         edge_cnt;
  logic [7:0]         div_top;

  assign accept   = (state_q == ST_IDLE) && req_valid;
  // Last gap half is one cycle short: the done cycle in IDLE
  // completes the nCS-high gap, so back-to-back gaps are exact.
  assign last_gap = (state_q == ST_GAP) &&
                    (edge_cnt == 5'(GAP_HALVES - 1));
  assign div_top  = last_gap ? 8'(CLK_DIV - 2) : 8'(CLK_DIV - 1);

  spi_clk_gen u_clk_gen (
    .clk       (clk),
    .rst       (rst),
    .en        (state_q != ST_IDLE),
    .clr       (state_d != state_q),
    .tog_en    (state_q == ST_SHIFT),
    .div_top   (div_top),
    .half_done (half_done),
    .rise      (rise),
    .fall      (fall),
    .sclk      (sclk),
    .edge_cnt  (edge_cnt)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign SCLK      = sclk;
  assign COPI      = sr_q[FRAME_W-1];
  assign nCS       = ncs_q;
  assign done      = done_q;

  // Frame sequencing: setup, 32 SCLK half-periods, hold, gap.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (req_valid) state_d = ST_SETUP;
      ST_SETUP: if (half_done) state_d = ST_SHIFT;
      ST_SHIFT: if (half_done && edge_cnt == 5'd31) state_d = ST_HOLD;
      ST_HOLD:  if (half_done) state_d = ST_GAP;
      ST_GAP:   if (half_done && last_gap) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Shift register and registered pin/strobe values.
  always_comb begin
    sr_d = sr_q;
    if (accept) sr_d = pack_frame(req_rw, req_addr, req_data);
    else if (fall && edge_cnt != 5'd31) sr_d = {sr_q[FRAME_W-2:0], 1'b0};
    else if (state_q == ST_HOLD && half_done) sr_d = '0;
    ncs_d  = (state_d == ST_IDLE) || (state_d == ST_GAP);
    done_d = (state_q == ST_GAP) && (state_d == ST_IDLE);
  end

  // State, shift register and pin flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      ncs_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      ncs_q   <= ncs_d;
      done_q  <= done_d;
    end
  end

`ifdef SPI_CTRL_READBACK_EN
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] rx_q, rx_d, rsp_q, rsp_d;

  // Capture CIPO on rising edges 9..16 of read frames.
  always_comb begin
    rw_d  = rw_q;
    rx_d  = rx_q;
    rsp_d = rsp_q;
    if (accept) rw_d = req_rw;
    if (rise && edge_cnt[4] && !rw_q) rx_d = {rx_q[DATA_W-2:0], CIPO};
    if (done_d && !rw_q) rsp_d = rx_q;
  end

  // Readback registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rw_q  <= 1'b0;
      rx_q  <= '0;
      rsp_q <= '0;
    end else begin
      rw_q  <= rw_d;
      rx_q  <= rx_d;
      rsp_q <= rsp_d;
    end
  end

  assign rsp_data = rsp_q;
`else
  logic unused;
  assign unused = rise;
`endif

endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: table-driven frames, queue scoreboard and
// pin monitor for two controller instances (CLK_DIV 4 and 2).
module tb_spi_controller;
  import spi_pkg::*;

  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
    logic [15:0] frame;
  } vec_t;

  typedef struct {
    logic [15:0] frame;
    int          low;
    int          lat;
    int          acc;
    logic [7:0]  rsp;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       sel = 1'b0;
  logic       req_rw = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       va, vb;
  assign va = req_valid & ~sel;
  assign vb = req_valid & sel;

  logic rdy_a, sclk_a, copi_a, ncs_a, busy_a, done_a;
  logic rdy_b, sclk_b, copi_b, ncs_b, busy_b, done_b;
`ifdef SPI_CTRL_READBACK_EN
  logic       cipo = 1'b0;
  logic [7:0] cipo_val = 8'hC3;
  logic [7:0] rsp_a, rsp_b, m_rsp;
  assign m_rsp = sel ? rsp_b : rsp_a;
`endif

  spi_controller #(.CLK_DIV(4), .GAP_HALVES(2)) u_a (
    .clk(clk), .rst(rst), .req_valid(va), .req_ready(rdy_a),
    .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
    .SCLK(sclk_a), .COPI(copi_a), .nCS(ncs_a),
    .busy(busy_a), .done(done_a)
`ifdef SPI_CTRL_READBACK_EN
    , .CIPO(cipo), .rsp_data(rsp_a)
`endif
  );

  spi_controller #(.CLK_DIV(2), .GAP_HALVES(2)) u_b (
    .clk(clk), .rst(rst), .req_valid(vb), .req_ready(rdy_b),
    .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
    .SCLK(sclk_b), .COPI(copi_b), .nCS(ncs_b),
    .busy(busy_b), .done(done_b)
`ifdef SPI_CTRL_READBACK_EN
    , .CIPO(cipo), .rsp_data(rsp_b)
`endif
  );

  logic m_sclk, m_copi, m_ncs, m_done, m_ready, m_valid;
  assign m_sclk  = sel ? sclk_b : sclk_a;
  assign m_copi  = sel ? copi_b : copi_a;
  assign m_ncs   = sel ? ncs_b : ncs_a;
  assign m_done  = sel ? done_b : done_a;
  assign m_ready = sel ? rdy_b : rdy_a;
  assign m_valid = req_valid;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  exp_t exp_q[$];
  logic [7:0] exp_rsp = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)",
                  nm, act, act, req, req);
  endtask

  // Pin monitor state
  logic        ps_sclk = 1'b0, ps_copi = 1'b0, ps_ncs = 1'b1;
  logic        rise_d = 1'b0, b2b_pend = 1'b0;
  logic [15:0] bits = '0;
  int rises = 0, tot_rises = 0, unstable = 0, stray = 0;
  int low_run = 0, high_run = 0, dones = 0;
  int bad_per = 0, last_rise = 0;

  always @(negedge clk) begin
    logic rise;
    exp_t e;
    rise = !ps_sclk && m_sclk;
    if (m_sclk != ps_sclk && m_ncs && ps_ncs) stray++;
    if (m_ncs) begin
      high_run = ps_ncs ? high_run + 1 : 1;
    end else begin
      if (ps_ncs) begin
        if (b2b_pend) chk("gap_ncs_high", high_run, sel ? 4 : 8);
        b2b_pend = 1'b0;
        bits = '0;
        rises = 0;
        unstable = 0;
        bad_per = 0;
        low_run = 0;
        rise_d = 1'b0;
      end
      low_run++;
    end
    if (rise_d && m_copi != ps_copi) unstable++;
    rise_d = rise && !m_ncs;
    if (rise_d) begin
      bits = {bits[14:0], m_copi};
      rises++;
      tot_rises++;
      if (m_copi != ps_copi) unstable++;
      if (rises > 1 && cyc - last_rise != (sel ? 4 : 8)) bad_per++;
      last_rise = cyc;
    end
`ifdef SPI_CTRL_READBACK_EN
    if (!m_ncs && rises >= 8 && rises < 16) cipo = cipo_val[15-rises];
    else cipo = 1'b0;
`endif
    if (m_done) begin
      dones++;
      chk("done_has_pending", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("frame_bits", int'(bits), int'(e.frame));
        chk("rise_count", rises, 16);
        chk("copi_stable", unstable, 0);
        chk("sclk_period", bad_per, 0);
        chk("ncs_low_cycles", low_run, e.low);
        chk("accept_to_done", cyc - e.acc + 1, e.lat);
        chk("stray_sclk", stray, 0);
`ifdef SPI_CTRL_READBACK_EN
        chk("rsp_data", int'(m_rsp), int'(e.rsp));
`endif
      end
      if (m_ready && m_valid) b2b_pend = 1'b1;
    end
    ps_sclk = m_sclk;
    ps_copi = m_copi;
    ps_ncs  = m_ncs;
  end

  // Drives one request (caller is at a negedge); returns at the
  // negedge after acceptance with req_valid still high.
  task automatic send(input vec_t v, input int low, input int lat,
                      output logic in_done);
    exp_t e;
    logic got;
    got = 1'b0;
    in_done = 1'b0;
    req_rw = v.rw;
    req_addr = v.addr;
    req_data = v.data;
    req_valid = 1'b1;
    for (int n = 0; n < 400 && !got; n++) begin
      if (m_ready) begin
        e.frame = v.frame;
        e.low = low;
        e.lat = lat;
        e.acc = cyc;
        e.rsp = exp_rsp;
        exp_q.push_back(e);
        in_done = m_done;
        got = 1'b1;
      end
      @(negedge clk);
    end
    chk("accept_in_time", int'(got), 1);
  endtask

  task automatic wait_dones(input int target, input int budget);
    int n;
    n = 0;
    while (dones < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_in_time", int'(dones >= target), 1);
    @(negedge clk);
  endtask

  initial begin
    vec_t tv[6];
    logic ind;
    int   d0, r0, n;
    tv[0] = '{1'b1, 7'h04, 8'h80, 16'h8480};
    tv[1] = '{1'b1, 7'h00, 8'hFF, 16'h80FF};
    tv[2] = '{1'b1, 7'h02, 8'h0F, 16'h820F};
    tv[3] = '{1'b1, 7'h01, 8'hA5, 16'h81A5};
    tv[4] = '{1'b1, 7'h03, 8'h3C, 16'h833C};
    tv[5] = '{1'b1, 7'h55, 8'hAA, 16'hD5AA};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ncs", int'(ncs_a), 1);
    chk("rst_sclk", int'(sclk_a), 0);
    chk("rst_copi", int'(copi_a), 0);
    chk("rst_ready", int'(rdy_a), 1);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_ncs_b", int'(ncs_b), 1);
`ifdef SPI_CTRL_READBACK_EN
    chk("rst_rsp", int'(rsp_a), 0);
`endif

    // Single write frame
    send(tv[0], 136, 145, ind);
    req_valid = 1'b0;
    wait_dones(1, 300);

    // Two frames with req_valid held high
    send(tv[1], 136, 145, ind);
    send(tv[2], 136, 145, ind);
    chk("accept_in_done", int'(ind), 1);
    req_valid = 1'b0;
    wait_dones(3, 400);

    // Reset at the 7th rising edge aborts the frame
    send(tv[5], 136, 145, ind);
    req_valid = 1'b0;
    r0 = tot_rises;
    n = 0;
    while (tot_rises < r0 + 7 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reached_rise7", tot_rises - r0, 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ncs", int'(ncs_a), 1);
    chk("abort_sclk", int'(sclk_a), 0);
    chk("abort_copi", int'(copi_a), 0);
    chk("abort_busy", int'(busy_a), 0);
    exp_q.delete();
    d0 = dones;
    repeat (200) @(negedge clk);
    chk("no_done_after_abort", dones, d0);
    send(tv[3], 136, 145, ind);
    req_valid = 1'b0;
    wait_dones(d0 + 1, 300);

    // CLK_DIV=2 instance
    sel = 1'b1;
    @(negedge clk);
    d0 = dones;
    send(tv[4], 68, 73, ind);
    req_valid = 1'b0;
    wait_dones(d0 + 1, 200);
    sel = 1'b0;
    @(negedge clk);

    // Whole table back-to-back
    d0 = dones;
    for (int i = 0; i < 6; i++) send(tv[i], 136, 145, ind);
    req_valid = 1'b0;
    wait_dones(d0 + 6, 1200);

`ifdef SPI_CTRL_READBACK_EN
    // Read frame captures CIPO; following write keeps rsp_data
    begin
      vec_t rd;
      rd = '{1'b0, 7'h04, 8'h00, 16'h0400};
      d0 = dones;
      exp_rsp = 8'hC3;
      send(rd, 136, 145, ind);
      req_valid = 1'b0;
      wait_dones(d0 + 1, 300);
      send(tv[0], 136, 145, ind);
      req_valid = 1'b0;
      wait_dones(d0 + 2, 300);
    end
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
